// File: rtl/pat_det_pkg.sv
// -----------------------------------------------------------------------------
// pat_det_pkg
// Shared constants and helpers for the pattern-detection scheduler:
//   - power-on pattern (3'b110) and length (3)
//   - default maximum pattern length and match counter width
//   - clamp_len: limits a requested pattern length to the engine maximum
// -----------------------------------------------------------------------------
package pat_det_pkg;

  localparam int         PLEN_MAX_DEF = 8;
  localparam int         CNT_W_DEF    = 8;
  localparam logic [2:0] DEF_PATTERN  = 3'b110;
  localparam logic [3:0] DEF_LEN      = 4'd3;

  // Lengths above the engine maximum behave as the maximum.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned plen_max);
    logic [3:0] len_c;
    if ({28'd0, len} > plen_max) begin
      len_c = plen_max[3:0];
    end else begin
      len_c = len;
    end
    return len_c;
  endfunction

endpackage

// File: rtl/pat_det_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with its own rotating pointer.
//   clk, rstn : clock, synchronous active-low reset
//   en        : grant enable; when low no grant is issued
//   req       : NCH request lines
//   gnt       : one-hot grant (combinational from req, en and the pointer)
//   gnt_idx   : index of the granted request
//   gnt_any   : a grant (and hence a transfer) is happening this cycle
// Every grant is a transfer, so the pointer moves past the granted index
// whenever gnt_any is high and holds otherwise.
// -----------------------------------------------------------------------------
module rr_arbiter
  import pat_det_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [CHW-1:0] ptr_r;
  logic [CHW-1:0] idx_v;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    gnt     = {NCH{1'b0}};
    gnt_idx = {CHW{1'b0}};
    gnt_any = 1'b0;
    idx_v   = {CHW{1'b0}};
    if (en) begin
      for (int k = 0; k < NCH; k++) begin
        idx_v = CHW'((int'(ptr_r) + k) % NCH);
        if (!gnt_any && req[idx_v]) begin
          gnt[idx_v] = 1'b1;
          gnt_idx    = idx_v;
          gnt_any    = 1'b1;
        end else begin
          // earlier hit already taken, or no request here
          gnt_any = gnt_any;
        end
      end
    end else begin
      gnt_any = 1'b0;
    end
  end

  // Pointer moves to the channel after the one just served.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_r <= {CHW{1'b0}};
    end else if (gnt_any) begin
      if (gnt_idx == CHW'(NCH - 1)) begin
        ptr_r <= {CHW{1'b0}};
      end else begin
        ptr_r <= gnt_idx + CHW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/pat_det_sched.sv
// -----------------------------------------------------------------------------
// pat_det_sched
// One programmable pattern-match engine shared by NCH serial bit channels.
// A round-robin arbiter accepts at most one bit per cycle; each channel keeps
// its own shift history, fill count and saturating match counter.
//   clk, rstn        : clock, synchronous active-low reset
//   cfg_we           : load cfg_pattern / cfg_len, clears all histories
//   cfg_pattern      : pattern, bit [len-1] is the first bit received
//   cfg_len          : pattern length (0 disables, > PLEN_MAX clamped)
//   cnt_clr          : clear all match counters
//   ch_valid, ch_bit : per-channel serial input
//   ch_ready         : one-hot grant (combinational, never from ch_bit)
//   match_valid      : one-cycle registered match pulse
//   match_ch         : channel of the last match
//   cnt_rd_ch        : counter read select
//   cnt_rd_data      : registered counter of the selected channel
// Build option PAT_DET_OVERLAP_EN: when defined, history and fill survive a
// match (overlapping detection); otherwise fill restarts at 0 after a match.
// -----------------------------------------------------------------------------
module pat_det_sched
  import pat_det_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int PLEN_MAX = PLEN_MAX_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int CHW      = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_we,
  input  logic [PLEN_MAX-1:0] cfg_pattern,
  input  logic [3:0]          cfg_len,
  input  logic                cnt_clr,
  input  logic [NCH-1:0]      ch_valid,
  input  logic [NCH-1:0]      ch_bit,
  output logic [NCH-1:0]      ch_ready,
  output logic                match_valid,
  output logic [CHW-1:0]      match_ch,
  input  logic [CHW-1:0]      cnt_rd_ch,
  output logic [CNT_W-1:0]    cnt_rd_data
);

  localparam int FW = $clog2(PLEN_MAX + 1);

  logic [PLEN_MAX-1:0] pattern_r;
  logic [3:0]          len_r;
  logic [PLEN_MAX-1:0] hist_r [NCH];
  logic [FW-1:0]       fill_r [NCH];
  logic [CNT_W-1:0]    cnt_r  [NCH];
  logic                match_valid_r;
  logic [CHW-1:0]      match_ch_r;
  logic [CNT_W-1:0]    cnt_rd_data_r;

  logic                arb_en_s;
  logic [NCH-1:0]      gnt_s;
  logic [CHW-1:0]      g_s;
  logic                xfer_s;
  logic                bit_s;
  logic [PLEN_MAX-1:0] new_hist_s;
  logic [PLEN_MAX-1:0] mask_s;
  logic [FW-1:0]       fill_sat_s;
  logic [FW-1:0]       fill_nxt_s;
  logic                match_s;

  // Nothing is accepted while reconfiguring or in reset.
  assign arb_en_s = rstn & ~cfg_we;

  rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .en      (arb_en_s),
    .req     (ch_valid),
    .gnt     (gnt_s),
    .gnt_idx (g_s),
    .gnt_any (xfer_s)
  );

  assign ch_ready    = gnt_s;
  assign match_valid = match_valid_r;
  assign match_ch    = match_ch_r;
  assign cnt_rd_data = cnt_rd_data_r;

  // Shared engine: next history of the granted channel and the match test.
  always_comb begin
    bit_s      = ch_bit[g_s];
    new_hist_s = {hist_r[g_s][PLEN_MAX-2:0], bit_s};
    mask_s     = {PLEN_MAX{1'b0}};
    for (int i = 0; i < PLEN_MAX; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    if (int'(fill_r[g_s]) >= PLEN_MAX) begin
      fill_sat_s = fill_r[g_s];
    end else begin
      fill_sat_s = fill_r[g_s] + FW'(1'b1);
    end
    // fill+1 counts the incoming bit; only the low len bits are compared
    if (xfer_s && (len_r != 4'd0) && ((int'(fill_r[g_s]) + 1) >= int'(len_r)) &&
        (((new_hist_s ^ pattern_r) & mask_s) == {PLEN_MAX{1'b0}})) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
`ifdef PAT_DET_OVERLAP_EN
    fill_nxt_s = fill_sat_s;
`else
    if (match_s) begin
      fill_nxt_s = {FW{1'b0}};
    end else begin
      fill_nxt_s = fill_sat_s;
    end
`endif
  end

  // Pattern and length configuration.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pattern_r <= PLEN_MAX'(DEF_PATTERN);
      len_r     <= DEF_LEN;
    end else if (cfg_we) begin
      pattern_r <= cfg_pattern;
      len_r     <= clamp_len(cfg_len, PLEN_MAX);
    end
  end

  // Per-channel shift history and fill count.
  always_ff @(posedge clk) begin
    if (!rstn || cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        hist_r[i] <= {PLEN_MAX{1'b0}};
        fill_r[i] <= {FW{1'b0}};
      end
    end else if (xfer_s) begin
      hist_r[g_s] <= new_hist_s;
      fill_r[g_s] <= fill_nxt_s;
    end
  end

  // Registered match pulse and channel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      match_valid_r <= 1'b0;
      match_ch_r    <= {CHW{1'b0}};
    end else begin
      match_valid_r <= match_s;
      if (match_s) begin
        match_ch_r <= g_s;
      end
    end
  end

  // Saturating match counters, bumped from the registered pulse; clear wins.
  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else if (match_valid_r && (cnt_r[match_ch_r] != {CNT_W{1'b1}})) begin
      cnt_r[match_ch_r] <= cnt_r[match_ch_r] + CNT_W'(1'b1);
    end
  end

  // Counter read port; an out-of-range select reads 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_rd_data_r <= {CNT_W{1'b0}};
    end else if (int'(cnt_rd_ch) < NCH) begin
      cnt_rd_data_r <= cnt_r[cnt_rd_ch];
    end else begin
      cnt_rd_data_r <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_pat_det_sched.sv
// -----------------------------------------------------------------------------
// tb_pat_det_sched
// Self-checking bench for pat_det_sched (NCH=4, PLEN_MAX=8, CNT_W=2).
// A reference model tracks, per channel, the bits received since the last
// clear, and decides matches from the last len bits; outputs are compared on
// every falling edge. Directed scenarios add literal expectations, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_pat_det_sched;

  localparam int NCH     = 4;
  localparam int PLEN    = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PAT_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             clk;
  logic             rstn;
  logic             cfg_we;
  logic [PLEN-1:0]  cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cnt_clr;
  logic [NCH-1:0]   ch_valid;
  logic [NCH-1:0]   ch_bit;
  logic [NCH-1:0]   ch_ready;
  logic             match_valid;
  logic [1:0]       match_ch;
  logic [1:0]       cnt_rd_ch;
  logic [CNT_W-1:0] cnt_rd_data;

  pat_det_sched #(.NCH(NCH), .PLEN_MAX(PLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cnt_clr     (cnt_clr),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .cnt_rd_ch   (cnt_rd_ch),
    .cnt_rd_data (cnt_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  int m_ptr;
  int m_hist [NCH];
  int m_n    [NCH];
  int m_cnt  [NCH];
  int m_pat, m_len, m_mc, m_rd;
  bit m_mv;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int last_mc = 0;
  int last_ready = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (!rstn || cfg_we) return -1;
    for (int k = 0; k < NCH; k++) begin
      if (ch_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    g = exp_grant();
    last_ready = int'(ch_ready);
    cmp("ch_ready", int'(ch_ready), (g < 0) ? 0 : (1 << g));
    cmp("match_valid", int'(match_valid), int'(m_mv));
    if (m_mv) cmp("match_ch", int'(match_ch), m_mc);
    cmp("cnt_rd_data", int'(cnt_rd_data), m_rd);
    if (match_valid) begin
      pulses++;
      last_mc = int'(match_ch);
    end
  endtask

  task automatic model_step();
    int g, mask, nrd;
    bit hit;
    if (!rstn) begin
      m_ptr = 0; m_pat = 6; m_len = 3; m_mv = 1'b0; m_mc = 0; m_rd = 0;
      for (int i = 0; i < NCH; i++) begin
        m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      nrd = m_cnt[cnt_rd_ch];
      if (cnt_clr) begin
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else if (m_mv && m_cnt[m_mc] < CNT_MAX) begin
        m_cnt[m_mc]++;
      end
      m_rd = nrd;
      if (cfg_we) begin
        m_pat = int'(cfg_pattern);
        m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
        for (int i = 0; i < NCH; i++) begin
          m_hist[i] = 0; m_n[i] = 0;
        end
        m_mv = 1'b0;
      end else begin
        g = exp_grant();
        if (g >= 0) begin
          m_hist[g] = ((m_hist[g] << 1) | int'(ch_bit[g])) & 16'hFFFF;
          m_n[g]++;
          mask = (1 << m_len) - 1;
          hit = (m_len != 0) && (m_n[g] >= m_len) && ((m_hist[g] & mask) == (m_pat & mask));
          if (hit && !OVL) m_n[g] = 0;
          m_ptr = (g + 1) % NCH;
          m_mv = hit;
          if (hit) m_mc = g;
        end else begin
          m_mv = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    ch_valid = '0;
    repeat (n) cycle();
  endtask

  task automatic send(input int c, input bit b);
    ch_valid = '0; ch_bit = '0;
    ch_valid[c] = 1'b1;
    ch_bit[c] = b;
    cycle();
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    ch_valid = '0;
    cfg_pattern = p; cfg_len = l; cfg_we = 1'b1;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; ch_valid = '0;
    cycle(); cycle();
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] pat_a5;
    rstn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cnt_clr = 1'b0;
    ch_valid = '0; ch_bit = '0; cnt_rd_ch = '0;
    @(posedge clk);
    model_step();
    #1;

    // reset defaults
    do_reset();
    cmp("rst_match_valid", int'(match_valid), 0);
    cmp("rst_match_ch", int'(match_ch), 0);
    cmp("rst_cnt_rd", int'(cnt_rd_data), 0);

    // ch0 sends 1,1,0
    pulses = 0; cnt_rd_ch = 2'd0;
    send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
    idle(4);
    cmp("ch0_110_pulses", pulses, 1);
    cmp("ch0_110_ch", last_mc, 0);
    cmp("ch0_110_cnt", int'(cnt_rd_data), 1);
    cmp("model_cnt0", m_cnt[0], 1);

    // ch1 continuously valid, 1,1,1,1,0
    pulses = 0; cnt_rd_ch = 2'd1;
    send(1, 1'b1); send(1, 1'b1); send(1, 1'b1); send(1, 1'b1); send(1, 1'b0);
    idle(4);
    cmp("ch1_11110_pulses", pulses, 1);
    cmp("ch1_11110_ch", last_mc, 1);
    cmp("ch1_cnt", int'(cnt_rd_data), 1);

    // all channels valid: rotation 0,1,2,3 and ch2 receives 1,1,0
    do_reset();
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NCH; s++) begin
        ch_valid = 4'hF;
        ch_bit = (r < 2) ? 4'b0100 : 4'b0000;
        cycle();
        cmp("rr_order", last_ready, 1 << s);
      end
    end
    idle(4);
    cmp("rr_ch2_pulses", pulses, 1);
    cmp("rr_ch2_ch", last_mc, 2);

    // pattern 11 len 2, ch0 sends 1,1,1
    cfg(8'b0000_0011, 4'd2);
    pulses = 0;
    send(0, 1'b1); send(0, 1'b1); send(0, 1'b1);
    idle(3);
    cmp("overlap_pulses", pulses, OVL ? 2 : 1);

    // counter saturation, then clear colliding with an increment
    cfg(8'b0000_0011, 4'd2);
    cnt_rd_ch = 2'd0;
    for (int i = 0; i < 10; i++) send(0, 1'b1);
    idle(4);
    cmp("cnt_saturate", int'(cnt_rd_data), 3);
    send(0, 1'b1); send(0, 1'b1);
    ch_valid = '0; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    idle(4);
    cmp("cnt_clr_wins", int'(cnt_rd_data), 0);

    // reconfiguration in the middle of a pattern drops history
    cfg(8'b0000_0110, 4'd3);
    pulses = 0;
    send(0, 1'b1); send(0, 1'b1);
    cfg(8'b0000_0110, 4'd3);
    send(0, 1'b0);
    idle(3);
    cmp("cfg_mid_pulses", pulses, 0);

    // length 0 disables matching
    cfg(8'h00, 4'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) send($urandom_range(0, 3), 1'b0);
    idle(3);
    cmp("len0_pulses", pulses, 0);

    // length 12 behaves as 8
    cfg(8'hA5, 4'd12);
    pulses = 0;
    pat_a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) send(3, pat_a5[i]);
    idle(3);
    cmp("len12_pulses", pulses, 1);
    cmp("len12_ch", last_mc, 3);

    // reset during the completing bit: no stale pulse
    do_reset();
    pulses = 0; cnt_rd_ch = 2'd0;
    send(0, 1'b1); send(0, 1'b1);
    rstn = 1'b0; ch_valid = 4'b0001; ch_bit = 4'b0000;
    cycle();
    rstn = 1'b1;
    idle(3);
    cmp("rst_mid_pulses", pulses, 0);
    cmp("rst_mid_cnt", int'(cnt_rd_data), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rstn        = ($urandom_range(0, 299) != 0);
      cfg_we      = ($urandom_range(0, 59) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      cnt_clr     = ($urandom_range(0, 49) == 0);
      ch_valid    = 4'($urandom);
      ch_bit      = 4'($urandom);
      cnt_rd_ch   = 2'($urandom);
      cycle();
    end
    rstn = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pat_det_sched.md
# pat_det_sched

Time-multiplexed serial pattern-detection scheduler: shares one programmable pattern-match engine among NCH serial bit channels. A round-robin arbiter accepts at most one bit per cycle. Each channel has its own shift history, fill count and saturating match counter. It sits between the serial stimulus sources and the match-event consumers in the sequential pattern-detector area, generalising single-channel fixed detectors such as a "110" detector.

## Interface
- NCH, 4: number of serial channels (2..8); CHW = $clog2(NCH)
- PLEN_MAX, 8: maximum pattern length in bits
- CNT_W, 8: per-channel match counter width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low; clock clk
- cfg_we  in  1  load cfg_pattern/cfg_len
- cfg_pattern  in  PLEN_MAX  pattern; bit [len-1] is the first bit received
- cfg_len  in  4  pattern length; 0 disables matching; values > PLEN_MAX are clamped to PLEN_MAX
- cnt_clr  in  1  clear all match counters
- ch_valid  in  NCH  per-channel bit valid
- ch_bit  in  NCH  per-channel serial bit
- ch_ready  out  NCH  one-hot grant; transfer = ch_valid[i] & ch_ready[i]
- match_valid  out  1  one-cycle match pulse
- match_ch  out  CHW  channel that matched
- cnt_rd_ch  in  CHW  counter read select
- cnt_rd_data  out  CNT_W  counter of the selected channel, registered

## Operation
- Reset: pattern=3'b110, len=3, rr pointer=0, all hist/fill/counters=0, match_valid=0, match_ch=0, cnt_rd_data=0.
- Arbiter:
  - Grants the first channel with ch_valid set, searching from the rr pointer upward and wrapping.
  - ch_ready is combinational from ch_valid and the pointer, and never depends on ch_bit.
  - At most one bit of ch_ready is high; all are 0 when no channel is valid, or when cfg_we or !rstn is asserted.
  - After a transfer on channel g, pointer <= (g+1) mod NCH. The pointer holds when there is no transfer.
- Accepted bit b on channel g:
  - hist[g] <= {hist[g][PLEN_MAX-2:0], b}
  - fill[g] <= min(fill[g]+1, PLEN_MAX)
- Match condition: len != 0, fill[g]+1 >= len, and the low len bits of the new history equal the low len bits of the pattern.
- On a match:
  - match_valid=1 and match_ch=g in the next cycle.
  - cnt[g] increments, saturating at 2^CNT_W-1.
- cfg_we:
  - Latches the pattern and the clamped length.
  - Clears every hist and fill. Counters are not cleared.
  - No transfer occurs in that cycle.
  - A match pulse already registered from the previous cycle still appears.
- cnt_clr: zeroes all counters. A simultaneous increment loses to the clear.
- cnt_rd_data <= cnt[cnt_rd_ch] every cycle.
- Reset asserted mid-stream: all state returns to reset values at the next edge, and no match pulse follows.

## Timing
- Bit accepted at edge N → match_valid high during cycle N+1 for exactly one cycle.
- Counter increment is visible on cnt_rd_data at edge N+2.
- Throughput: one bit per cycle aggregate. With all NCH channels valid, each channel is served exactly once per NCH cycles.
- No combinational path from ch_bit to any output.

## Configuration
- PAT_DET_OVERLAP_EN defined: overlapping detection. History and fill are kept after a match. Pattern 11 on input 1,1,1 gives 2 matches.
- Undefined: non-overlapping detection. fill[g] is cleared to 0 on a match, so the next match needs len fresh bits. Same input gives 1 match.

## Structure
- Package pat_det_pkg holds:
  - default pattern 3'b110 and default length 3
  - PLEN_MAX, CNT_W defaults
  - the length-clamp function
- Sub-module rr_arbiter (NCH requests, pointer, one-hot grant) is instantiated once.
- Per-channel hist/fill/cnt registers and the match compare stay in pat_det_sched.

## Test plan
- Reset defaults; ch0 sends 1,1,0 → match_valid one cycle after the 0, match_ch=0, cnt_rd_data(ch0)=1.
- ch1 valid throughout, sending 1,1,1,1,0 → only one match, after the final 0 (matches the 110 semantics).
- All 4 channels valid continuously → ch_ready grants in order 0,1,2,3,0…; each channel receives 1 bit per 4 cycles; per-channel histories stay independent and ch2 stream 110 matches with match_ch=2.
- cfg_we pattern 8'b11, len 2; ch0 sends 1,1,1 → 2 matches with PAT_DET_OVERLAP_EN, 1 without.
- Counter with CNT_W=2, 5 matches → saturates at 3; cnt_clr in the same cycle as a match increment → reads 0.
- cfg_we mid-pattern after ch0 sends 1,1 → history cleared, a following 0 gives no match; cfg_len=0 → no matches; cfg_len=12 → behaves as 8; rstn low mid-stream → outputs 0 and no stale match pulse.
